// File: rtl/key_sched_w.sv
`default_nettype none
// ============================================================================
//  Module   : key_sched_w
//  Brief    : Word-serial AES-256 key expansion. Emits round-key words
//             w0..w59 one per valid/ready handshake, tagged with round number,
//             column index and a last flag. All outputs come from flops.
//  Revision : 1.0  initial release
// ============================================================================

// Forward AES S-box as a 256-entry constant table (entry 0 at the MSB end).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n sits at bit offset (255-n)*8; 255-n is simply ~n.
  logic [10:0] idx_w;
  assign idx_w    = {~in_byte, 3'b000};
  assign out_byte = C_SBOX[idx_w +: 8];
endmodule

module key_sched_w (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic [3:0]   out_round,
  output logic [1:0]   out_col,
  output logic         out_last,
  output logic         done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] C_LAST_IDX = 6'd59;

  state_t      state_q, state_d;
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [5:0]  i_q, i_d;
  logic        last_q, last_d;
  logic        done_q, done_d;

  logic [31:0] sub_w;     // SubWord(W[7])
  logic [31:0] t_w;       // mixing term for the next word
  logic [7:0]  rcon_w;

  // SubWord: four S-box lookups on the newest window word.
  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (win_q[7][8*b +: 8]),
        .out_byte (sub_w[8*b +: 8])
      );
    end
  endgenerate

  // Rcon for j = i+8 at j%8==0: index j/8 = i[5:3]+1. Index 8 is never output.
  always_comb begin
    rcon_w = 8'h00;
    case (i_q[5:3])
      3'd0:    rcon_w = 8'h01;
      3'd1:    rcon_w = 8'h02;
      3'd2:    rcon_w = 8'h04;
      3'd3:    rcon_w = 8'h08;
      3'd4:    rcon_w = 8'h10;
      3'd5:    rcon_w = 8'h20;
      3'd6:    rcon_w = 8'h40;
      default: rcon_w = 8'h00;
    endcase
  end

  // Mixing term. j%8 equals i%8 since j = i+8. SubWord(RotWord(x)) equals
  // RotWord(SubWord(x)), so the same four S-boxes serve both cases.
  always_comb begin
    t_w = win_q[7];
    if (i_q[2:0] == 3'd0) begin
      t_w = {sub_w[23:0], sub_w[31:24]} ^ {rcon_w, 24'h000000};
    end else if (i_q[2:0] == 3'd4) begin
      t_w = sub_w;
    end
  end

  // Next-state: load on start, slide window on accept, finish after w59.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    last_d  = last_q;
    done_d  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      win_d[k] = win_q[k];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < 8; k++) begin
            win_d[k] = key[255-32*k -: 32];
          end
          i_d     = 6'd0;
          last_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (i_q == C_LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            last_d  = 1'b0;
          end else begin
            for (int k = 0; k < 7; k++) begin
              win_d[k] = win_q[k+1];
            end
            win_d[7] = win_q[0] ^ t_w;
            i_d      = i_q + 6'd1;
            last_d   = (i_q == C_LAST_IDX - 6'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, window and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 6'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      last_q  <= last_d;
      done_q  <= done_d;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_RUN);
  assign out_word  = win_q[0];
  assign out_round = i_q[5:2];
  assign out_col   = i_q[1:0];
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_key_sched_w.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_sched_w
//  Brief    : Self-checking bench for key_sched_w against an arithmetic
//             AES-256 key-expansion model (S-box built from GF(2^8) inverse).
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_sched_w;

  logic         clk;
  logic         rst_n;
  logic [255:0] key;
  logic         start;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [3:0]   out_round;
  logic [1:0]   out_col;
  logic         out_last;
  logic         done;

  key_sched_w dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_round (out_round),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] C_FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] C_ZERO_KEY = 256'h0;

  int tests;
  int fails;

  logic [7:0]  sbox_m [256];
  logic [31:0] exp_w  [60];
  logic [31:0] cap_w  [3][60];
  logic [3:0]  cap_r  [3][60];
  logic [1:0]  cap_c  [3][60];

  typedef struct {
    int          slot;
    int          idx;
    logic [31:0] word;
    logic [3:0]  rnd;
    logic [1:0]  col;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int n = 0; n < 8; n++) exp_w[n] = k[255-32*n -: 32];
    for (int j = 8; j < 60; j++) begin
      t = exp_w[j-1];
      if (j % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (j % 8 == 4) begin
        t = subword(t);
      end
      exp_w[j] = exp_w[j-8] ^ t;
    end
  endtask

  task automatic begin_start(input logic [255:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume one full expansion starting at the negedge after start was taken.
  task automatic stream(input logic [255:0] k, input bit rand_ready, input int inject_at,
                        input int slot, input bit chain, input logic [255:0] chain_key);
    int          idx = 0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] pw;
    logic [3:0]  pr;
    logic [1:0]  pc;
    bit          rdy;
    expand(k);
    while (idx < 60 && cyc < 3000) begin
      if (inject_at >= 0 && idx == inject_at && !prev_stall) begin
        key   = ~C_FIPS_KEY;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        check("stall_hold", {out_valid, out_word, out_round, out_col}, {1'b1, pw, pr, pc});
      end else begin
        check($sformatf("word%0d", idx),
              {out_valid, out_word, out_round, out_col, out_last},
              {1'b1, exp_w[idx], 4'(idx / 4), 2'(idx % 4), (idx == 59)});
        cap_w[slot][idx] = out_word;
        cap_r[slot][idx] = out_round;
        cap_c[slot][idx] = out_col;
      end
      rdy        = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready  = rdy;
      pw         = out_word;
      pr         = out_round;
      pc         = out_col;
      prev_stall = !rdy;
      if (rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (idx < 60) begin
      check("stream_timeout", 64'(idx), 64'd60);
    end
    check("done_pulse", {out_valid, busy, done}, {1'b0, 1'b0, 1'b1});
    if (chain) begin
      key   = chain_key;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_clear", {done, out_valid}, {1'b0, chain});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    key       = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    build_sbox();

    vecs[0] = '{0,  0, 32'h603deb10, 4'd0,  2'd0};
    vecs[1] = '{0,  7, 32'h0914dff4, 4'd1,  2'd3};
    vecs[2] = '{0,  8, 32'h9ba35411, 4'd2,  2'd0};
    vecs[3] = '{0, 12, 32'ha8b09c1a, 4'd3,  2'd0};
    vecs[4] = '{0, 59, 32'h706c631e, 4'd14, 2'd3};
    vecs[5] = '{1,  0, 32'h00000000, 4'd0,  2'd0};
    vecs[6] = '{1,  8, 32'h62636363, 4'd2,  2'd0};
    vecs[7] = '{1,  9, 32'h62636363, 4'd2,  2'd1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, out_valid, out_word, out_round, out_col, out_last, done}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, out_valid}, 2'b00);

    // Reference key, continuous ready.
    begin_start(C_FIPS_KEY);
    stream(C_FIPS_KEY, 1'b0, -1, 0, 1'b0, '0);

    // Reference key, random backpressure.
    begin_start(C_FIPS_KEY);
    stream(C_FIPS_KEY, 1'b1, -1, 2, 1'b0, '0);

    // Start with another key mid-run must be ignored.
    begin_start(C_FIPS_KEY);
    stream(C_FIPS_KEY, 1'b0, 20, 2, 1'b0, '0);

    // Asynchronous reset at i=33.
    begin_start(C_FIPS_KEY);
    out_ready = 1'b1;
    repeat (33) @(negedge clk);
    expand(C_FIPS_KEY);
    check("pre_reset_word33", {out_word, out_round, out_col}, {exp_w[33], 4'd8, 2'd1});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, out_valid, out_word, out_round, out_col, out_last, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_resume", {busy, out_valid}, 2'b00);

    // Zero key, chained straight into the reference key in the done cycle.
    begin_start(C_ZERO_KEY);
    stream(C_ZERO_KEY, 1'b0, -1, 1, 1'b1, C_FIPS_KEY);
    stream(C_FIPS_KEY, 1'b1, -1, 2, 1'b0, '0);

    // Known-answer table against captured words.
    for (int v = 0; v < 8; v++) begin
      check($sformatf("kat_s%0d_w%0d", vecs[v].slot, vecs[v].idx),
            {cap_w[vecs[v].slot][vecs[v].idx], cap_r[vecs[v].slot][vecs[v].idx],
             cap_c[vecs[v].slot][vecs[v].idx]},
            {vecs[v].word, vecs[v].rnd, vecs[v].col});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
